// File: rtl/avg_seq_pkg.sv
// avg_seq_pkg: shared defaults, derived widths and FSM state encoding for the
// sequenced nearest-to-average filter (avg_seq_ctrl / avg_window_buf).
package avg_seq_pkg;

    localparam int unsigned AVG_WIDTH = 16;
    localparam int unsigned AVG_DEPTH = 12;
    localparam int unsigned ACC_W     = AVG_WIDTH + $clog2(AVG_DEPTH);
    localparam int unsigned PTR_W     = $clog2(AVG_DEPTH);

    typedef enum logic [2:0] {
        S_FILL,
        S_IDLE,
        S_SUM,
        S_DIV,
        S_SCAN,
        S_OUT
    } state_t;

    // Accumulator width that can hold the sum of d samples of w bits.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned d);
        return w + $clog2(d);
    endfunction

endpackage

// File: rtl/avg_window_buf.sv
// avg_window_buf: DEPTH x WIDTH circular sample store.
//   clk, reset : clock, asynchronous active-high reset (write pointer only)
//   i_we       : write i_wdata at the write pointer, then advance it (wrapping)
//   i_wdata    : sample to store
//   i_raddr    : combinational read index (scan counter of the controller)
//   o_rdata    : entry at i_raddr
// Storage contents are intentionally not reset.
module avg_window_buf
    import avg_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = AVG_WIDTH,
    parameter int unsigned DEPTH    = AVG_DEPTH,
    parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic [PTR_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]    o_rdata
);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
        end else if (i_we) begin
            r_wp <= (r_wp == PTR_BITS'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_wp] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/avg_seq_ctrl.sv
// avg_seq_ctrl: sequenced nearest-to-average filter over a DEPTH-sample window.
// Each accepted sample triggers a DEPTH-cycle sum pass, a one-cycle divide and
// a DEPTH-cycle scan for the window entry closest to the truncated mean.
//   clk, reset           : clock, asynchronous active-high reset
//   din, in_valid        : sample input, accepted when in_valid && in_ready
//   in_ready             : high in FILL and IDLE only
//   dout, out_valid      : selected sample, transferred when out_valid && out_ready
//   out_ready            : consumer ready
//   primed               : window has been filled once since reset
module avg_seq_ctrl
    import avg_seq_pkg::*;
#(
    parameter int unsigned WIDTH = AVG_WIDTH,
    parameter int unsigned DEPTH = AVG_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             primed
);

    localparam int unsigned ACC_BITS = acc_width(WIDTH, DEPTH);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    state_t              r_state, w_next;
    logic [PTR_BITS-1:0] r_fill, r_idx;
    logic [ACC_BITS-1:0] r_acc;
    logic [WIDTH-1:0]    r_avg, r_best_val, r_best_diff, r_dout;
    logic [WIDTH-1:0]    w_rdata, w_diff;
    logic                r_primed, r_in_ready, r_out_valid;
    logic                w_accept, w_last, w_take, w_in_ready_nxt, w_out_valid_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_idx == PTR_BITS'(DEPTH - 1));
    assign w_diff   = (w_rdata >= r_avg) ? (w_rdata - r_avg) : (r_avg - w_rdata);
    // Smaller value wins a tie, so the result does not depend on scan order.
    assign w_take   = (r_idx == '0) || (w_diff < r_best_diff) ||
                      ((w_diff == r_best_diff) && (w_rdata < r_best_val));

    avg_window_buf #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_accept),
        .i_wdata (din),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:  if (w_accept && (r_fill == PTR_BITS'(DEPTH - 1))) w_next = S_SUM;
            S_IDLE:  if (w_accept) w_next = S_SUM;
            S_SUM:   if (w_last) w_next = S_DIV;
            S_DIV:   w_next = S_SCAN;
            S_SCAN:  if (w_last) w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_FILL;
        endcase
    end

    // Handshake outputs are registered from the next state so they are
    // glitch-free and read 0 while reset is asserted.
    always_comb begin
        w_in_ready_nxt  = (w_next == S_FILL) || (w_next == S_IDLE);
        w_out_valid_nxt = (w_next == S_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
            r_fill      <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_avg       <= '0;
            r_best_val  <= '0;
            r_best_diff <= '0;
            r_dout      <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_fill <= r_fill + 1'b1;
                        r_acc  <= '0;
                        r_idx  <= '0;
                        if (r_fill == PTR_BITS'(DEPTH - 1)) begin
                            r_primed <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_SUM: begin
                    r_acc <= r_acc + ACC_BITS'(w_rdata);
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                S_DIV: begin
                    r_avg <= WIDTH'(r_acc / ACC_BITS'(DEPTH));
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_best_val  <= w_rdata;
                        r_best_diff <= w_diff;
                    end
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    // Capture the final winner (including the last entry) so
                    // dout is already stable on the first OUT cycle.
                    if (w_last) begin
                        r_dout <= w_take ? w_rdata : r_best_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign primed    = r_primed;

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// tb_avg_seq_ctrl: self-checking bench for avg_seq_ctrl (WIDTH=16, DEPTH=12).
module tb_avg_seq_ctrl;

    localparam int DEPTH = 12;
    localparam int LAT   = 2 * DEPTH + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dout;
    logic        out_valid;
    logic        out_ready;
    logic        primed;

    int          cyc = 0;
    int          acc_cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] last_dout;
    logic [15:0] win[$];

    typedef struct {
        string       name;
        logic [15:0] s [DEPTH];
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    avg_seq_ctrl #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .primed    (primed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: nearest window entry to the truncated mean, smaller value on ties.
    function automatic logic [15:0] model();
        longint      sum = 0;
        longint      avg, d, bd;
        logic [15:0] bv;
        foreach (win[i]) sum += win[i];
        avg = sum / DEPTH;
        bv  = win[0];
        bd  = (win[0] > avg) ? win[0] - avg : avg - win[0];
        foreach (win[i]) begin
            d = (win[i] > avg) ? win[i] - avg : avg - win[i];
            if (d < bd || (d == bd && win[i] < bv)) begin
                bd = d;
                bv = win[i];
            end
        end
        return bv;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [15:0] s);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        din      = s;
        in_valid = 1'b1;
        acc_cyc  = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        din      = 16'($urandom);
        win.push_back(s);
        if (win.size() > DEPTH) void'(win.pop_front());
    endtask

    task automatic wait_result(input logic [15:0] exp, input string nm);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({nm, "_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        check({nm, "_lat"}, 32'(cyc - acc_cyc), 32'(LAT));
        check(nm, 32'(dout), 32'(exp));
        last_dout = dout;
        if (out_ready) begin
            @(negedge clk);
            check({nm, "_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    function automatic logic [15:0] rnd_sample();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 20));
            2:       return 16'($urandom_range(16'hFFF0, 16'hFFFF));
            default: return ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;

        for (int i = 0; i < DEPTH; i++) begin
            vecs[0].s[i] = (i < 6) ? 16'd4 : 16'd8;
            vecs[1].s[i] = (i % 2 == 1) ? 16'd4 : 16'd8;
            vecs[2].s[i] = (i < 6) ? 16'd8 : 16'd4;
            vecs[3].s[i] = 16'hFFFF;
            vecs[4].s[i] = (i == DEPTH - 1) ? 16'hFFFF : 16'h0000;
        end
        vecs[0].name = "tie_grouped";     vecs[0].exp = 16'd4;
        vecs[1].name = "tie_interleaved"; vecs[1].exp = 16'd4;
        vecs[2].name = "tie_reversed";    vecs[2].exp = 16'd4;
        vecs[3].name = "all_ffff";        vecs[3].exp = 16'hFFFF;
        vecs[4].name = "zeros_one_max";   vecs[4].exp = 16'h0000;

        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_primed", 32'(primed), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Fill with 1..12.
        for (int i = 1; i <= DEPTH; i++) begin
            send(16'(i));
            check("fill_no_valid", 32'(out_valid), 32'd0);
            check("fill_primed", 32'(primed), (i == DEPTH) ? 32'd1 : 32'd0);
        end
        check("fill_busy_ready", 32'(in_ready), 32'd0);
        wait_result(16'd6, "fill_avg");
        send(16'd13);
        wait_result(16'd7, "slide_13");

        // Table vectors: every intermediate window checked against the model,
        // the complete window against the table value.
        foreach (vecs[v]) begin
            for (int i = 0; i < DEPTH; i++) begin
                send(vecs[v].s[i]);
                wait_result(model(), {vecs[v].name, "_model"});
            end
            check(vecs[v].name, 32'(last_dout), 32'(vecs[v].exp));
        end

        // Backpressure in OUT with noisy input.
        out_ready = 1'b0;
        send(rnd_sample());
        wait_result(model(), "bp_first");
        held = dout;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            din      = 16'($urandom);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_dout", 32'(dout), 32'(held));
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(out_valid), 32'd0);
        send(rnd_sample());
        wait_result(model(), "bp_after");

        // Randomised windows.
        for (int i = 0; i < 24; i++) begin
            send(rnd_sample());
            wait_result(model(), "rand");
        end

        // Reset during SCAN.
        send(rnd_sample());
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_primed", 32'(primed), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rel_valid", 32'(out_valid), 32'd0);
        check("mid_rel_primed", 32'(primed), 32'd0);
        check("mid_rel_ready", 32'(in_ready), 32'd1);
        win.delete();
        for (int i = 0; i < DEPTH - 1; i++) begin
            send(rnd_sample());
            check("refill_no_valid", 32'(out_valid), 32'd0);
        end
        repeat (30) @(negedge clk);
        check("refill_idle_valid", 32'(out_valid), 32'd0);
        check("refill_idle_primed", 32'(primed), 32'd0);
        send(rnd_sample());
        check("refill_primed", 32'(primed), 32'd1);
        wait_result(model(), "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avg_seq_ctrl.md
Name: avg_seq_ctrl

Overview:
Sequenced controller for the nearest-to-average sample filter. It keeps a DEPTH-entry sliding window of input samples in a circular buffer. For each new sample it runs a multi-cycle sum pass and then a scan pass over the window. The output is the window sample closest to the truncated window mean. It replaces the single-cycle 12-input combinational datapath with one adder and one comparator, sits between the sample source and the downstream consumer, and uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, sample width in bits
DEPTH, 12, window length in samples (>=2)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
din  input  WIDTH  sample in
in_valid  input  1  din valid
in_ready  output  1  controller accepts din this cycle
dout  output  WIDTH  selected sample
out_valid  output  1  dout valid
out_ready  input  1  consumer accepts dout
primed  output  1  window full; outputs now being produced

Behaviour:
- Accept on in_valid && in_ready at a rising edge. Output transfer on out_valid && out_ready at a rising edge.
- Reset values: in_ready=0, out_valid=0, dout=0, primed=0, state=FILL, fill count=0, write pointer=0. Buffer contents are not reset.
- States: FILL, IDLE, SUM, DIV, SCAN, OUT.
- FILL: in_ready=1.
  - Each accept writes buf[wp] and advances wp, wrapping at DEPTH-1 to 0.
  - On the DEPTH-th accept: primed<=1, go to SUM.
  - No output is produced during FILL.
- IDLE: in_ready=1.
  - An accept overwrites the oldest entry (buf[wp]), advances wp, and goes to SUM.
- SUM: exactly DEPTH cycles. acc accumulates every entry once.
  - acc width = WIDTH+ceil(log2(DEPTH)) = 20 bits by default, so it never overflows.
  - acc is cleared on entry.
- DIV: 1 cycle. avg <= acc / DEPTH, truncated toward zero, WIDTH bits.
- SCAN: exactly DEPTH cycles. diff = |buf[i] - avg|, computed unsigned with no wrap.
  - The first entry initialises best_val and best_diff.
  - Replace the best when diff < best_diff, or when diff == best_diff and buf[i] < best_val.
  - With this rule the result is independent of scan order.
- OUT: out_valid=1, dout=best_val.
  - dout is stable while out_valid=1 and out_ready=0.
  - On transfer go to IDLE, with out_valid=0 from the next cycle.
  - dout holds its last value outside OUT.
- in_ready=0 in SUM, DIV, SCAN and OUT. din presented there is ignored; no state changes.
- Latency: an accept edge at cycle 0 gives SUM in cycles 1..DEPTH, DIV in cycle DEPTH+1, SCAN in DEPTH+2..2*DEPTH+1, and out_valid high from cycle 2*DEPTH+2 (26 by default).
- Throughput: at most one result per 2*DEPTH+3 cycles, given a same-cycle out_ready and a new in_valid in IDLE.
- Window content for a result: the last DEPTH accepted samples, including the triggering one.
- Reset mid-operation (any state): return immediately to the reset values. DEPTH fresh samples are required before the next output, and any pending result is discarded.
- The primed flag stays 1 until reset.

Decomposition:
- Package avg_seq_pkg:
  - WIDTH/DEPTH defaults
  - ACC_W = WIDTH+$clog2(DEPTH)
  - PTR_W = $clog2(DEPTH)
  - state enum {FILL, IDLE, SUM, DIV, SCAN, OUT}
- Sub-module avg_window_buf: DEPTH x WIDTH circular storage with one write port (wp, wrap) and one combinational read port indexed by the controller's scan counter.
- The FSM, accumulator, divider and min-tracker stay in avg_seq_ctrl.

Test Plan:
- Reset, then feed 1..12 with out_ready=1.
  - Required: no out_valid during fill; primed=1 after the 12th accept.
  - Required: out_valid 26 cycles after the 12th accept, with dout=6 (sum 78, avg 6).
- Then feed 13 (window 2..13, sum 90, avg 7): dout=7 exactly 26 cycles after the accept.
- Tie-break: window of six 4s and six 8s (avg 6, both diffs 2): dout=4 regardless of arrival order.
- Width extremes:
  - Twelve samples of 0xFFFF: acc=0xBFFF4, avg=0xFFFF, dout=0xFFFF.
  - Window {0x0000 x11, 0xFFFF}: avg=0x1555, dout=0x0000.
- Backpressure: hold out_ready=0 for 10 cycles in OUT while toggling in_valid/din.
  - Required: out_valid=1, dout constant, in_ready=0, and the window unchanged (the next result matches the model).
- Assert reset during SCAN.
  - Required: out_valid=0, primed=0, in_ready=1 immediately after reset release.
  - Required: 11 new samples produce no output; the 12th triggers a result computed only on the new samples.
